// File: rtl/player_pkg.sv
// Shared types and helpers for the player motion engine.
// Holds the player state enum, keycodes and packed-slot slicing.
package player_pkg;

  typedef enum logic [1:0] {
    ST_LAUNCH,
    ST_RISING,
    ST_FALLING,
    ST_DEAD
  } player_state_t;

  localparam logic [7:0] KEY_LEFT  = 8'd4;
  localparam logic [7:0] KEY_RIGHT = 8'd7;

  localparam int SLOT_VEC_W = 1024;
  localparam int SLOT_W     = 16;

  // Slot i of width w from a packed vector; caller narrows the result.
  function automatic logic [SLOT_W-1:0] slot(
    input logic [SLOT_VEC_W-1:0] vec,
    input int unsigned           i,
    input int unsigned           w
  );
    logic [SLOT_W-1:0] mask;
    mask = SLOT_W'((32'd1 << w) - 32'd1);
    return SLOT_W'(vec >> (i * w)) & mask;
  endfunction

endpackage

// File: rtl/plat_hit_detect.sv
// Combinational landing test of the player box against every platform.
// Lowest-index hitting slot wins; snap_y is where the player top must sit.
module plat_hit_detect
  import player_pkg::*;
#(
  parameter int COORD_W  = 11,
  parameter int NUM_PLAT = 8,
  parameter int SIZE_X   = 8,
  parameter int SIZE_Y   = 10,
  parameter int SNAP_TOL = 5,
  parameter int IDX_W    = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
  input  logic signed [COORD_W+1:0]   pos_x,
  input  logic signed [COORD_W+1:0]   pos_y,
  input  logic [NUM_PLAT*COORD_W-1:0] plat_x,
  input  logic [NUM_PLAT*COORD_W-1:0] plat_y,
  input  logic [NUM_PLAT*COORD_W-1:0] plat_w,
  input  logic [NUM_PLAT-1:0]         plat_valid,
  output logic                        hit,
  output logic [IDX_W-1:0]            hit_idx,
  output logic [COORD_W-1:0]          snap_y
);

  localparam int SW = COORD_W + 2;
  typedef logic signed [SW-1:0] s_t;

  s_t cx, foot, px, py, pw;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    snap_y  = '0;
    cx      = pos_x + s_t'(SIZE_X / 2);
    foot    = pos_y + s_t'(SIZE_Y);
    px      = '0;
    py      = '0;
    pw      = '0;
    // Walk downward so the lowest hitting index is assigned last.
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      px = s_t'({2'b00, COORD_W'(slot(SLOT_VEC_W'(plat_x), i, COORD_W))});
      py = s_t'({2'b00, COORD_W'(slot(SLOT_VEC_W'(plat_y), i, COORD_W))});
      pw = s_t'({2'b00, COORD_W'(slot(SLOT_VEC_W'(plat_w), i, COORD_W))});
      if (plat_valid[i] &&
          (px <= cx) && (cx <= px + pw) &&
          (py - s_t'(SNAP_TOL) <= foot) &&
          (foot < py + s_t'(SNAP_TOL))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        snap_y  = COORD_W'(py - s_t'(SIZE_Y));
      end
    end
  end

endmodule

// File: rtl/player_motion_engine.sv
// Per-frame player physics: gravity, jump, X motion, landing and death.
// Define SCREEN_WRAP_EN to wrap X at the screen edges instead of clamping.
module player_motion_engine
  import player_pkg::*;
#(
  parameter int COORD_W   = 11,
  parameter int VEL_W     = 8,
  parameter int NUM_PLAT  = 8,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int SIZE_X    = 8,
  parameter int SIZE_Y    = 10,
  parameter int X_START   = 280,
  parameter int Y_START   = 460,
  parameter int X_STEP    = 1,
  parameter int JUMP_VEL  = 3,
  parameter int GRAV_LOG2 = 3,
  parameter int MAX_FALL  = 6,
  parameter int SNAP_TOL  = 5
) (
  input  logic                        frame_clk,
  input  logic                        Reset,
  input  logic [7:0]                  keycode,
  input  logic [NUM_PLAT*COORD_W-1:0] plat_x,
  input  logic [NUM_PLAT*COORD_W-1:0] plat_y,
  input  logic [NUM_PLAT*COORD_W-1:0] plat_w,
  input  logic [NUM_PLAT-1:0]         plat_valid,
  output logic [COORD_W-1:0]          PlayerX,
  output logic [COORD_W-1:0]          PlayerY,
  output logic signed [VEL_W-1:0]     vel_y,
  output player_state_t               state,
  output logic [15:0]                 jump_count,
  output logic                        land_pulse,
  output logic                        game_over
);

  localparam int SW    = COORD_W + 2;
  localparam int IDX_W = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  typedef logic signed [SW-1:0] s_t;

  localparam s_t X_MAX  = s_t'(SCREEN_W - SIZE_X);
  localparam s_t FLOOR  = s_t'(SCREEN_H - 1);
  localparam s_t Y_DEAD = s_t'(SCREEN_H - 1 - SIZE_Y);
  localparam logic signed [VEL_W-1:0] V_JUMP = VEL_W'(-JUMP_VEL);
  localparam logic signed [VEL_W-1:0] V_MAX  = VEL_W'(MAX_FALL);

  logic [COORD_W-1:0]          x_q, x_d, y_q, y_d;
  logic signed [VEL_W-1:0]     vel_q, vel_d, vel_n;
  logic [GRAV_LOG2-1:0]        grav_cnt_q, grav_cnt_d;
  player_state_t               state_q, state_d;
  logic [15:0]                 jump_cnt_q, jump_cnt_d;
  logic                        land_q, land_d;
  logic                        over_q, over_d;
  s_t                          x_nxt, y_nxt, x_s;

  logic                        hit;
  logic [IDX_W-1:0]            hit_idx_unused;
  logic [COORD_W-1:0]          snap_y;

  plat_hit_detect #(
    .COORD_W  (COORD_W),
    .NUM_PLAT (NUM_PLAT),
    .SIZE_X   (SIZE_X),
    .SIZE_Y   (SIZE_Y),
    .SNAP_TOL (SNAP_TOL),
    .IDX_W    (IDX_W)
  ) u_hit (
    .pos_x      (x_nxt),
    .pos_y      (y_nxt),
    .plat_x     (plat_x),
    .plat_y     (plat_y),
    .plat_w     (plat_w),
    .plat_valid (plat_valid),
    .hit        (hit),
    .hit_idx    (hit_idx_unused),
    .snap_y     (snap_y)
  );

  // Free-running motion for this frame, before landing/death decisions.
  always_comb begin
    vel_n = vel_q;
    if (state_q == ST_LAUNCH) begin
      vel_n = V_JUMP;
    end else if (grav_cnt_q == '1) begin
      vel_n = (vel_q >= V_MAX) ? V_MAX : vel_q + VEL_W'(1);
    end
    y_nxt = s_t'({2'b00, y_q}) + s_t'(vel_n);
    x_s   = s_t'({2'b00, x_q});
    x_nxt = x_s;
    if (keycode == KEY_LEFT) begin
      x_nxt = x_s - s_t'(X_STEP);
`ifdef SCREEN_WRAP_EN
      if (x_nxt < 0) x_nxt = X_MAX;
`else
      if (x_nxt < 0) x_nxt = '0;
`endif
    end else if (keycode == KEY_RIGHT) begin
      x_nxt = x_s + s_t'(X_STEP);
`ifdef SCREEN_WRAP_EN
      if (x_nxt > X_MAX) x_nxt = '0;
`else
      if (x_nxt > X_MAX) x_nxt = X_MAX;
`endif
    end
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    vel_d      = vel_q;
    grav_cnt_d = grav_cnt_q;
    state_d    = state_q;
    jump_cnt_d = jump_cnt_q;
    land_d     = 1'b0;
    over_d     = over_q;
    if (state_q != ST_DEAD) begin
      grav_cnt_d = grav_cnt_q + GRAV_LOG2'(1);
      x_d        = COORD_W'(x_nxt);
      y_d        = COORD_W'(y_nxt);
      vel_d      = vel_n;
      case (state_q)
        ST_LAUNCH:  state_d = ST_RISING;
        ST_RISING:  if (vel_n >= 0) state_d = ST_FALLING;
        default:    state_d = state_q;
      endcase
      if (y_nxt < 0) begin
        y_d     = '0;
        vel_d   = '0;
        state_d = ST_FALLING;
      end else if (state_q == ST_FALLING && hit) begin
        y_d        = snap_y;
        vel_d      = V_JUMP;
        grav_cnt_d = '0;
        jump_cnt_d = (jump_cnt_q == 16'hFFFF) ? jump_cnt_q
                                              : jump_cnt_q + 16'd1;
        land_d     = 1'b1;
        state_d    = ST_RISING;
      end else if (state_q == ST_FALLING &&
                   y_nxt + s_t'(SIZE_Y) >= FLOOR) begin
        y_d     = COORD_W'(Y_DEAD);
        state_d = ST_DEAD;
        over_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      x_q        <= COORD_W'(X_START);
      y_q        <= COORD_W'(Y_START);
      vel_q      <= '0;
      grav_cnt_q <= '0;
      state_q    <= ST_LAUNCH;
      jump_cnt_q <= '0;
      land_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      vel_q      <= vel_d;
      grav_cnt_q <= grav_cnt_d;
      state_q    <= state_d;
      jump_cnt_q <= jump_cnt_d;
      land_q     <= land_d;
      over_q     <= over_d;
    end
  end

  assign PlayerX    = x_q;
  assign PlayerY    = y_q;
  assign vel_y      = vel_q;
  assign state      = state_q;
  assign jump_count = jump_cnt_q;
  assign land_pulse = land_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_player_motion_engine.sv
// Directed bench for player_motion_engine; a second, taller instance
// gives the player room to reach terminal fall speed.
module tb_player_motion_engine;
  import player_pkg::*;

  localparam int CW = 11;
  localparam int NP = 8;

  logic             frame_clk = 1'b0;
  logic             Reset;
  logic [7:0]       keycode;
  logic [NP*CW-1:0] plat_x, plat_y, plat_w;
  logic [NP-1:0]    plat_valid;
  logic [NP*CW-1:0] no_plat;
  logic [NP-1:0]    no_valid;

  logic [CW-1:0]    px, py;
  logic signed [7:0] vy;
  player_state_t    st;
  logic [15:0]      jc;
  logic             lp, go;

  logic [CW-1:0]    t_x_unused, t_y;
  logic signed [7:0] t_vy;
  player_state_t    t_st;
  logic [15:0]      t_jc_unused;
  logic             t_lp_unused, t_go;

  int checks   = 0;
  int failures = 0;

  always #5 frame_clk = ~frame_clk;

  player_motion_engine u_dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .plat_x     (plat_x),
    .plat_y     (plat_y),
    .plat_w     (plat_w),
    .plat_valid (plat_valid),
    .PlayerX    (px),
    .PlayerY    (py),
    .vel_y      (vy),
    .state      (st),
    .jump_count (jc),
    .land_pulse (lp),
    .game_over  (go)
  );

  player_motion_engine #(.SCREEN_H(2000)) u_tall (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (8'd0),
    .plat_x     (no_plat),
    .plat_y     (no_plat),
    .plat_w     (no_plat),
    .plat_valid (no_valid),
    .PlayerX    (t_x_unused),
    .PlayerY    (t_y),
    .vel_y      (t_vy),
    .state      (t_st),
    .jump_count (t_jc_unused),
    .land_pulse (t_lp_unused),
    .game_over  (t_go)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic clear_plats();
    plat_x = '0; plat_y = '0; plat_w = '0; plat_valid = '0;
  endtask

  task automatic set_plat0(input int x, input int y, input int w);
    plat_x[CW-1:0] = CW'(x);
    plat_y[CW-1:0] = CW'(y);
    plat_w[CW-1:0] = CW'(w);
    plat_valid     = 8'b0000_0001;
  endtask

  task automatic do_reset();
    Reset = 1'b1; keycode = 8'd0;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_plats();
    Reset = 1'b1; keycode = 8'd0;
    tick(2);
    checks++; if (px !== 11'd280) begin failures++; $display("FAIL reset_x got=%0d exp=280", px); end
    checks++; if (py !== 11'd460) begin failures++; $display("FAIL reset_y got=%0d exp=460", py); end
    checks++; if (vy !== 8'sd0) begin failures++; $display("FAIL reset_vel got=%0d exp=0", vy); end
    checks++; if (st !== ST_LAUNCH) begin failures++; $display("FAIL reset_state got=%0d exp=0", st); end
    checks++; if (jc !== 16'd0) begin failures++; $display("FAIL reset_jc got=%0d exp=0", jc); end
    checks++; if (lp !== 1'b0 || go !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", lp, go); end
    Reset = 1'b0;
    tick(1);
    checks++; if (vy !== -8'sd3) begin failures++; $display("FAIL launch_vel got=%0d exp=-3", vy); end
    checks++; if (st !== ST_RISING) begin failures++; $display("FAIL launch_state got=%0d exp=1", st); end
  endtask

  task automatic test_gravity();
    clear_plats();
    do_reset();
    tick(7);
    checks++; if (t_vy !== -8'sd3) begin failures++; $display("FAIL grav_f7 got=%0d exp=-3", t_vy); end
    tick(1);
    checks++; if (t_vy !== -8'sd2) begin failures++; $display("FAIL grav_f8 got=%0d exp=-2", t_vy); end
    tick(15);
    checks++; if (t_vy !== -8'sd1 || t_st !== ST_RISING) begin failures++; $display("FAIL grav_f23 got=%0d/%0d exp=-1/1", t_vy, t_st); end
    tick(1);
    checks++; if (t_vy !== 8'sd0 || t_st !== ST_FALLING) begin failures++; $display("FAIL grav_f24 got=%0d/%0d exp=0/2", t_vy, t_st); end
    checks++; if (t_y !== 11'd415) begin failures++; $display("FAIL grav_apex got=%0d exp=415", t_y); end
    tick(48);
    checks++; if (t_vy !== 8'sd6) begin failures++; $display("FAIL grav_f72 got=%0d exp=6", t_vy); end
    tick(8);
    checks++; if (t_vy !== 8'sd6) begin failures++; $display("FAIL grav_sat80 got=%0d exp=6", t_vy); end
    tick(8);
    checks++; if (t_vy !== 8'sd6 || t_go !== 1'b0) begin failures++; $display("FAIL grav_sat88 got=%0d/%b exp=6/0", t_vy, t_go); end
  endtask

  task automatic test_landing();
    clear_plats();
    set_plat0(240, 470, 80);
    do_reset();
    keycode = 8'd4;
    tick(4);
    checks++; if (px !== 11'd276) begin failures++; $display("FAIL land_x got=%0d exp=276", px); end
    keycode = 8'd0;
    tick(48);
    checks++; if (py !== 11'd454 || st !== ST_FALLING || jc !== 16'd0) begin failures++; $display("FAIL land_pre got=%0d/%0d/%0d exp=454/2/0", py, st, jc); end
    tick(1);
    checks++; if (py !== 11'd460) begin failures++; $display("FAIL land_y got=%0d exp=460", py); end
    checks++; if (vy !== -8'sd3 || st !== ST_RISING) begin failures++; $display("FAIL land_vel got=%0d/%0d exp=-3/1", vy, st); end
    checks++; if (jc !== 16'd1 || lp !== 1'b1) begin failures++; $display("FAIL land_cnt got=%0d/%b exp=1/1", jc, lp); end
    tick(1);
    checks++; if (lp !== 1'b0 || py !== 11'd457) begin failures++; $display("FAIL land_after got=%b/%0d exp=0/457", lp, py); end
  endtask

  task automatic test_rising_pass();
    plat_y[CW-1:0] = 11'd450;
    tick(7);
    checks++; if (vy !== -8'sd2 || py !== 11'd437) begin failures++; $display("FAIL pass_vel got=%0d/%0d exp=-2/437", vy, py); end
    checks++; if (lp !== 1'b0 || jc !== 16'd1 || st !== ST_RISING) begin failures++; $display("FAIL pass_a got=%b/%0d/%0d exp=0/1/1", lp, jc, st); end
    tick(1);
    checks++; if (lp !== 1'b0 || jc !== 16'd1 || py !== 11'd435) begin failures++; $display("FAIL pass_b got=%b/%0d/%0d exp=0/1/435", lp, jc, py); end
  endtask

  task automatic test_death();
    clear_plats();
    do_reset();
    tick(56);
    checks++; if (go !== 1'b0 || py !== 11'd467) begin failures++; $display("FAIL death_pre got=%b/%0d exp=0/467", go, py); end
    tick(1);
    checks++; if (st !== ST_DEAD || go !== 1'b1) begin failures++; $display("FAIL death_state got=%0d/%b exp=3/1", st, go); end
    checks++; if (py !== 11'd469) begin failures++; $display("FAIL death_y got=%0d exp=469", py); end
    keycode = 8'd7;
    tick(10);
    checks++; if (px !== 11'd280 || py !== 11'd469 || st !== ST_DEAD) begin failures++; $display("FAIL death_frozen got=%0d/%0d/%0d exp=280/469/3", px, py, st); end
    keycode = 8'd0;
    Reset = 1'b1;
    tick(1);
    checks++; if (px !== 11'd280 || py !== 11'd460 || vy !== 8'sd0) begin failures++; $display("FAIL death_reset_pos got=%0d/%0d/%0d exp=280/460/0", px, py, vy); end
    checks++; if (st !== ST_LAUNCH || go !== 1'b0 || jc !== 16'd0) begin failures++; $display("FAIL death_reset_st got=%0d/%b/%0d exp=0/0/0", st, go, jc); end
    Reset = 1'b0;
  endtask

  task automatic test_x_edge();
    logic [CW-1:0] exp_l, exp_r;
`ifdef SCREEN_WRAP_EN
    exp_l = 11'd632; exp_r = 11'd0;
`else
    exp_l = 11'd0;   exp_r = 11'd1;
`endif
    clear_plats();
    set_plat0(0, 470, 639);
    do_reset();
    keycode = 8'd4;
    tick(280);
    checks++; if (px !== 11'd0 || go !== 1'b0) begin failures++; $display("FAIL x_left got=%0d/%b exp=0/0", px, go); end
    tick(1);
    checks++; if (px !== exp_l) begin failures++; $display("FAIL x_left_edge got=%0d exp=%0d", px, exp_l); end
    keycode = 8'd7;
    tick(1);
    checks++; if (px !== exp_r) begin failures++; $display("FAIL x_right_step got=%0d exp=%0d", px, exp_r); end
    checks++; if (jc !== 16'd5) begin failures++; $display("FAIL x_bounces got=%0d exp=5", jc); end
    keycode = 8'd0;
  endtask

  initial begin
    no_plat  = '0;
    no_valid = '0;
    Reset    = 1'b1;
    keycode  = 8'd0;
    clear_plats();
    test_reset();
    test_gravity();
    test_landing();
    test_rising_pass();
    test_death();
    test_x_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
